uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Schedules the shared UART transmitter between two requesters:
  - the echo path, which buffers received bytes in an internal FIFO;
  - a local host byte source, via a valid/ready handshake.
- Detects byte completion from the receiver's ready level and the transmitter's ready level.
- Drives the transmitter's start/word inputs, one byte at a time, with round-robin arbitration.
- Sits between the receive block, the transmit block and the host-side logic in the echo-mode top level.

Parameters:
- FIFO_DEPTH, 8, echo FIFO entries; power of two, at least 2.
- FIFO_AW, 3, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- echo_en  in  1  1 = received bytes are queued for echo.
- rx_word  in  8  byte from the receiver; valid when rx_ready rises.
- rx_ready  in  1  receiver ready level; a rising edge marks a new byte.
- host_word  in  8  host byte to transmit.
- host_valid  in  1  host byte pending.
- host_ready  out  1  host byte accepted this cycle when high together with host_valid.
- tx_word  out  8  byte presented to the transmitter.
- tx_start  out  1  transmit request level; held until the byte completes.
- tx_done  in  1  transmitter ready level.
- fifo_count  out  FIFO_AW+1  echo FIFO occupancy.
- overflow  out  1  sticky: an echo byte was dropped.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx_start=0, tx_word=8'h00, host_ready=0, fifo_count=0, overflow=0.
  - state=IDLE; FIFO pointers=0; rx_ready edge register=0; last_grant=HOST, so echo wins the first tie.
  - Reset mid-transmission drops tx_start immediately; FIFO contents are discarded.
- rx_ready edge detection:
  - rx_rise = rx_ready & ~rx_ready_q, where rx_ready_q is a 1-cycle registered copy.
  - Push happens when rx_rise & echo_en.
- FIFO push/pop:
  - A push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set to 1. overflow clears only on reset.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - echo_en=0 blocks pushes only; queued bytes still drain.
- FSM states: IDLE, START, BUSY, GAP.
- IDLE:
  - req_e = (count!=0), req_h = host_valid.
  - If both requests are present, grant the requester that is not last_grant. Otherwise grant the one requesting.
  - On grant, in the same cycle:
    - tx_word <= FIFO head (echo) or host_word (host).
    - Pop the FIFO (echo), or assert host_ready=1 combinationally (host).
    - Update last_grant; next state=START.
  - No request: stay in IDLE.
  - host_ready is 1 only in an IDLE cycle with a host grant.
- START: tx_start=1. When tx_done==0 (transmitter has taken the byte), go to BUSY.
- BUSY: tx_start=1. When tx_done==1 (byte complete), go to GAP.
- GAP: tx_start=0 for exactly 1 cycle, then IDLE.
- Latency:
  - Grant cycle N gives tx_start=1 from N+1.
  - Minimum byte-to-byte spacing is START+BUSY+GAP+IDLE, i.e. 1 IDLE cycle + 1 GAP cycle of tx_start low.
- tx_word is stable from grant until the next grant.
- fifo_count is registered and updated on the cycle after a push/pop.

Decomposition:
- Shared package uart_pkg:
  - localparam BYTE_W=8.
  - FSM state enum {IDLE, START, BUSY, GAP} as 2-bit constants.
  - Grant encoding constants GRANT_ECHO=1'b0, GRANT_HOST=1'b1.
- One natural sub-module, uart_byte_fifo:
  - Parameterised DEPTH/AW, push/pop, head, count, full/empty.
  - Instantiated once for the echo path.

Test Plan:
- Reset with tx_done=1, echo_en=1, one rx_ready pulse carrying rx_word=8'h41 -> fifo_count=1, then tx_start=1 and tx_word=8'h41 two cycles after the push.
  - Model the transmitter: tx_done low 20 cycles, then high -> tx_start falls 1 cycle after tx_done rises; fifo_count=0.
- FIFO holds 2 bytes (8'h10, 8'h11) and host_valid=1 with host_word=8'hA5 from the start -> transmit order 10, A5, 11 (round-robin). host_ready is high for exactly 1 cycle.
- echo_en=1, transmitter stalled (tx_done held 0), 9 rx pulses with FIFO_DEPTH=8 -> fifo_count=8 and overflow=1. The first 8 bytes are transmitted in order once tx_done is released.
- echo_en=0, 3 rx pulses, no host traffic -> fifo_count stays 0, tx_start stays 0, overflow stays 0.
- Assert rst=0 asynchronously during BUSY with 4 bytes queued -> tx_start=0, fifo_count=0 and overflow=0 in the same cycle. After release, no transmission occurs without new input.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo/host transmit scheduler.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    GAP   = 2'd3
  } tx_state_t;

  localparam logic GRANT_ECHO = 1'b0;
  localparam logic GRANT_HOST = 1'b1;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte-wide circular FIFO with a registered occupancy count and a combinational head.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] head,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // A full FIFO still takes a byte when the same cycle frees a slot.
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between the echo FIFO and a host byte source.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               echo_en,
  input  logic [BYTE_W-1:0]  rx_word,
  input  logic               rx_ready,
  input  logic [BYTE_W-1:0]  host_word,
  input  logic               host_valid,
  output logic               host_ready,
  output logic [BYTE_W-1:0]  tx_word,
  output logic               tx_start,
  input  logic               tx_done,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  tx_state_t         state;
  logic              last_grant;
  logic              rx_ready_q;
  logic              rx_rise;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_head;
  logic              req_e;
  logic              req_h;
  logic              grant_any;
  logic              grant_sel;

  assign rx_rise = rx_ready & ~rx_ready_q;
  assign push    = rx_rise & echo_en;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_echo_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (rx_word),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // On a tie the requester that did not win last time gets the transmitter.
  always_comb begin
    req_e     = ~fifo_empty;
    req_h     = host_valid;
    grant_any = (state == IDLE) & (req_e | req_h);
    if (req_e && req_h) grant_sel = ~last_grant;
    else if (req_h)     grant_sel = GRANT_HOST;
    else                grant_sel = GRANT_ECHO;
  end

  assign pop        = grant_any & (grant_sel == GRANT_ECHO);
  assign host_ready = rst & grant_any & (grant_sel == GRANT_HOST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ready_q <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready;
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  // START waits for the transmitter to go busy, BUSY waits for it to report ready again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tx_start   <= 1'b0;
      tx_word    <= '0;
      last_grant <= GRANT_HOST;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            tx_word    <= (grant_sel == GRANT_HOST) ? host_word : fifo_head;
            last_grant <= grant_sel;
            tx_start   <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          tx_start <= 1'b1;
          if (!tx_done) state <= BUSY;
        end
        BUSY: begin
          if (tx_done) begin
            tx_start <= 1'b0;
            state    <= GAP;
          end else begin
            tx_start <= 1'b1;
          end
        end
        GAP: begin
          tx_start <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          tx_start <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched; the bench plays the transmitter's ready level.
module tb_uart_tx_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       echo_en = 1'b0;
  logic [7:0] rx_word = 8'h00;
  logic       rx_ready = 1'b0;
  logic [7:0] host_word = 8'h00;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic [7:0] tx_word;
  logic       tx_start;
  logic       tx_done = 1'b1;
  logic [3:0] fifo_count;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int hr_cnt = 0;

  uart_tx_sched #(
    .FIFO_DEPTH (8),
    .FIFO_AW    (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .echo_en    (echo_en),
    .rx_word    (rx_word),
    .rx_ready   (rx_ready),
    .host_word  (host_word),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .tx_word    (tx_word),
    .tx_start   (tx_start),
    .tx_done    (tx_done),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (host_valid && host_ready) hr_cnt++;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] w);
    rx_word  = w;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic serve(output logic [7:0] w, input bit drop_host);
    for (int i = 0; i < 100 && tx_start !== 1'b1; i++) @(negedge clk);
    checkOutput("start_wait", {31'd0, tx_start}, 32'd1);
    w = tx_word;
    if (drop_host) host_valid = 1'b0;
    tx_done = 1'b0;
    repeat (5) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    checkOutput("start_fall", {31'd0, tx_start}, 32'd0);
  endtask

  initial begin
    logic [7:0] w;
    int         hr_base;
    bit         seen;

    // Reset values, with host_valid high to prove host_ready stays low.
    host_valid = 1'b1;
    host_word  = 8'h5A;
    echo_en    = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_tx_start", {31'd0, tx_start}, 32'd0);
    checkOutput("rst_tx_word", {24'd0, tx_word}, 32'h00);
    checkOutput("rst_host_ready", {31'd0, host_ready}, 32'd0);
    checkOutput("rst_fifo_count", {28'd0, fifo_count}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    host_valid = 1'b0;
    do_reset();

    $display("[TB] single echo byte");
    rx_word  = 8'h41;
    rx_ready = 1'b1;
    @(negedge clk);
    checkOutput("t1_count_after_push", {28'd0, fifo_count}, 32'd1);
    checkOutput("t1_start_not_yet", {31'd0, tx_start}, 32'd0);
    rx_ready = 1'b0;
    @(negedge clk);
    checkOutput("t1_tx_start", {31'd0, tx_start}, 32'd1);
    checkOutput("t1_tx_word", {24'd0, tx_word}, 32'h41);
    checkOutput("t1_count_popped", {28'd0, fifo_count}, 32'd0);
    tx_done = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("t1_start_held", {31'd0, tx_start}, 32'd1);
    tx_done = 1'b1;
    @(negedge clk);
    checkOutput("t1_start_fall", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    checkOutput("t1_idle_low", {31'd0, tx_start}, 32'd0);
    checkOutput("t1_count_end", {28'd0, fifo_count}, 32'd0);

    $display("[TB] round-robin echo/host");
    do_reset();
    applyStimulus(8'h10);
    applyStimulus(8'h11);
    hr_base    = hr_cnt;
    host_word  = 8'hA5;
    host_valid = 1'b1;
    serve(w, 1'b0);
    checkOutput("rr_first", {24'd0, w}, 32'h10);
    serve(w, 1'b1);
    checkOutput("rr_second", {24'd0, w}, 32'hA5);
    serve(w, 1'b0);
    checkOutput("rr_third", {24'd0, w}, 32'h11);
    repeat (4) @(negedge clk);
    checkOutput("rr_host_ready_cycles", hr_cnt - hr_base, 32'd1);
    checkOutput("rr_idle", {31'd0, tx_start}, 32'd0);
    checkOutput("rr_count", {28'd0, fifo_count}, 32'd0);

    $display("[TB] overflow with stalled transmitter");
    do_reset();
    host_word  = 8'hEE;
    host_valid = 1'b1;
    tx_done    = 1'b0;
    @(negedge clk);
    checkOutput("ovf_host_start", {31'd0, tx_start}, 32'd1);
    checkOutput("ovf_host_word", {24'd0, tx_word}, 32'hEE);
    host_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) applyStimulus(8'h80 + 8'(i));
    checkOutput("ovf_count_full", {28'd0, fifo_count}, 32'd8);
    checkOutput("ovf_flag", {31'd0, overflow}, 32'd1);
    checkOutput("ovf_still_busy", {31'd0, tx_start}, 32'd1);
    tx_done = 1'b1;
    @(negedge clk);
    checkOutput("ovf_host_done", {31'd0, tx_start}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      serve(w, 1'b0);
      checkOutput($sformatf("ovf_order_%0d", i), {24'd0, w}, 32'h80 + i);
    end
    repeat (3) @(negedge clk);
    checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);
    checkOutput("ovf_drained", {28'd0, fifo_count}, 32'd0);
    checkOutput("ovf_ninth_dropped", {31'd0, tx_start}, 32'd0);

    $display("[TB] echo disabled");
    do_reset();
    echo_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h60 + 8'(i));
      checkOutput($sformatf("dis_count_%0d", i), {28'd0, fifo_count}, 32'd0);
    end
    repeat (5) @(negedge clk);
    checkOutput("dis_tx_start", {31'd0, tx_start}, 32'd0);
    checkOutput("dis_overflow", {31'd0, overflow}, 32'd0);

    $display("[TB] reset during BUSY");
    do_reset();
    echo_en = 1'b1;
    applyStimulus(8'h21);
    tx_done = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(8'h30 + 8'(i));
    checkOutput("mid_count_before", {28'd0, fifo_count}, 32'd4);
    checkOutput("mid_busy", {31'd0, tx_start}, 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
    checkOutput("mid_rst_count", {28'd0, fifo_count}, 32'd0);
    checkOutput("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst     = 1'b1;
    tx_done = 1'b1;
    seen    = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) seen = 1'b1;
    end
    checkOutput("post_rst_no_tx", {31'd0, seen}, 32'd0);
    checkOutput("post_rst_count", {28'd0, fifo_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
